temporizador_lavagem: RTL
=========================

# temporizador_lavagem

Plant-side companion to the washing-machine controller FSM. Consumes the controller's actuator commands (pump, agitate, spin, centrifuge) and produces the sensor and timer inputs that the controller waits on: water full/empty, end of the first agitation, end of spin, end of the second agitation, and end of centrifuge (dry). Used as the closed-loop partner of the controller in simulation and on the board in place of real sensors.

## Interface
Parameters:
- NIVEL_MAX, 8: water-level count at which the tub is full.
- T_AGITAR1, 20: cycles of first agitation before tempo1.
- T_GIRAR, 10: cycles of spin before tempo2.
- T_AGITAR2, 20: cycles of second agitation before tempo3.
- T_CENTRIF, 15: cycles of centrifuge before secar.
- CONT_W, 16: phase-counter width; every T_* must be ≤ 2^CONT_W−1.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- bomba_agua  in  1  pump command (fills the tub).
- modo_agitar  in  1  agitate command.
- modo_girar  in  1  spin command.
- modo_centrifugar  in  1  centrifuge command.
- cheio  out  1  tub full (nivel == NIVEL_MAX).
- vazio  out  1  tub empty (nivel == 0).
- tempo1  out  1  first agitation elapsed.
- tempo2  out  1  spin elapsed.
- tempo3  out  1  second agitation elapsed.
- secar  out  1  centrifuge elapsed.
- erro_modo  out  1  illegal command combination seen (only with the macro).

## Operation
- Mode decode, priority order: bomba_agua > modo_centrifugar > modo_girar > modo_agitar; none set gives PARADO. Mode set is PARADO, ENCHER, AGITAR, GIRAR, CENTRIF.
- Water level nivel, range 0..NIVEL_MAX:
  - ENCHER: +1 per cycle, saturating at NIVEL_MAX.
  - PARADO or CENTRIF: −1 per cycle, saturating at 0.
  - AGITAR or GIRAR: level held.
- cheio and vazio are decoded directly from the nivel register.
- Phase flag ja_girou:
  - Set on any edge that samples GIRAR.
  - Cleared on any edge that samples ENCHER.
  - It separates the first agitation (flag 0, drives tempo1) from the second (flag 1, drives tempo3).
- Phase counter cnt:
  - On an edge where the decoded mode differs from the registered previous mode modo_ant, cnt ← 1.
  - Otherwise cnt increments, saturating at 2^CONT_W−1.
  - modo_ant is updated every edge.
- Timer outputs are registered. At each edge, using the next value of cnt:
  - tempo1 ← AGITAR && !ja_girou && cnt ≥ T_AGITAR1.
  - tempo3 ← AGITAR && ja_girou && cnt ≥ T_AGITAR2. Here ja_girou is the value before this edge's update.
  - tempo2 ← GIRAR && cnt ≥ T_GIRAR.
  - secar ← CENTRIF && cnt ≥ T_CENTRIF.
- Timer outputs are levels: they stay high while the mode is held and drop at the first edge sampling a different mode.

## Timing
- Reset values:
  - nivel=0, so vazio=1 and cheio=0.
  - cnt=0, modo_ant=PARADO, ja_girou=0.
  - tempo1, tempo2, tempo3, secar and erro_modo are all 0.
- Reset assertion mid-operation clears all state immediately, without waiting for a clock edge.
- Fill latency: the first edge sampling bomba_agua=1 takes nivel 0→1. From empty, cheio rises after NIVEL_MAX edges of ENCHER.
- Drain latency: from full, vazio rises after NIVEL_MAX edges of PARADO or CENTRIF.
- Timer latency: a mode first sampled at edge k gives cnt=1 after edge k. tempoX/secar go high after edge k+T−1, i.e. the output is visible in the T-th cycle of the mode.
- Mode glitch: a one-cycle change of mode restarts cnt. There is no hysteresis.
- Saturation: nivel never wraps. cnt saturates and never wraps, so timer outputs stay high under saturation.

## Configuration
- TEMPORIZADOR_ERRO_EN defined:
  - erro_modo is set on any edge sampling two or more command inputs high.
  - It is sticky and cleared only by reset_n.
  - Decode priority is unchanged.
- Macro undefined: the detector logic is absent and erro_modo is tied to 0.

## Structure
- Shared package lavagem_pkg holds:
  - the mode enum (MODO_PARADO, MODO_ENCHER, MODO_AGITAR, MODO_GIRAR, MODO_CENTRIF);
  - default localparams for NIVEL_MAX and the T_* values, also reused by the controller bench.
- One sub-module, nivel_agua: the saturating up/down level counter with its cheio/vazio decode.
- Mode decode, the phase counter and the timer registers stay in the top module.

## Test plan
- Reset then idle: reset_n low then high, no commands for 5 cycles → vazio=1, cheio=0, all timer outputs 0.
- Fill: bomba_agua=1 from empty → cheio rises after edge 8 (defaults), nivel holds at 8, vazio falls after the first edge.
- First agitation then spin:
  - modo_agitar held after the fill → tempo1=1 in the 20th cycle; tempo3 stays 0.
  - Switch to modo_girar → tempo1 drops at the next edge; tempo2=1 in the 10th spin cycle.
- Second agitation and drain:
  - modo_agitar after the spin → tempo3=1 in the 20th cycle; tempo1 stays 0.
  - Commands off → vazio after 8 cycles.
  - modo_centrifugar held → secar in the 15th cycle.
- Reset mid-phase: reset_n pulsed low at cycle 10 of the spin → all outputs at reset values at once. After release, an agitation produces tempo1, not tempo3.
- With TEMPORIZADOR_ERRO_EN: bomba_agua and modo_agitar high together for 1 cycle → erro_modo=1 and held after the inputs clear; nivel increments (ENCHER priority).

Source files
------------

// File: rtl/lavagem_pkg.sv
// Shared modes and default timings for the washing-machine plant model.
// Also reused by the controller bench.
package lavagem_pkg;

  typedef enum logic [2:0] {
    MODO_PARADO,
    MODO_ENCHER,
    MODO_AGITAR,
    MODO_GIRAR,
    MODO_CENTRIF
  } modo_e;

  localparam int NIVEL_MAX_DEF = 8;
  localparam int T_AGITAR1_DEF = 20;
  localparam int T_GIRAR_DEF   = 10;
  localparam int T_AGITAR2_DEF = 20;
  localparam int T_CENTRIF_DEF = 15;
  localparam int CONT_W_DEF    = 16;

  function automatic modo_e decodifica(
    input logic bomba,
    input logic centrif,
    input logic girar,
    input logic agitar
  );
    if (bomba)        return MODO_ENCHER;
    else if (centrif) return MODO_CENTRIF;
    else if (girar)   return MODO_GIRAR;
    else if (agitar)  return MODO_AGITAR;
    else              return MODO_PARADO;
  endfunction

endpackage

// File: rtl/temporizador_lavagem_nivel_agua.sv
// Saturating water-level counter with full/empty decode.
// Fills in ENCHER, drains in PARADO/CENTRIF, holds otherwise.
module nivel_agua
  import lavagem_pkg::*;
#(
  parameter int NIVEL_MAX = NIVEL_MAX_DEF
) (
  input  logic  clock,
  input  logic  reset_n,
  input  modo_e modo_i,
  output logic  cheio_o,
  output logic  vazio_o
);

  localparam int NW = $clog2(NIVEL_MAX + 1);
  localparam logic [NW-1:0] NMAX = NW'(NIVEL_MAX);

  logic [NW-1:0] nivel_q, nivel_d;

  always_comb begin
    nivel_d = nivel_q;
    case (modo_i)
      MODO_ENCHER:
        if (nivel_q != NMAX) nivel_d = nivel_q + 1'b1;
      MODO_PARADO, MODO_CENTRIF:
        if (nivel_q != '0) nivel_d = nivel_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) nivel_q <= '0;
    else          nivel_q <= nivel_d;
  end

  assign cheio_o = (nivel_q == NMAX);
  assign vazio_o = (nivel_q == '0);

endmodule

// File: rtl/temporizador_lavagem.sv
// Plant-side sensor/timer model for the washing-machine controller.
// Optional sticky illegal-command flag: define TEMPORIZADOR_ERRO_EN.
module temporizador_lavagem
  import lavagem_pkg::*;
#(
  parameter int NIVEL_MAX = NIVEL_MAX_DEF,
  parameter int T_AGITAR1 = T_AGITAR1_DEF,
  parameter int T_GIRAR   = T_GIRAR_DEF,
  parameter int T_AGITAR2 = T_AGITAR2_DEF,
  parameter int T_CENTRIF = T_CENTRIF_DEF,
  parameter int CONT_W    = CONT_W_DEF
) (
  input  logic clock,
  input  logic reset_n,
  input  logic bomba_agua,
  input  logic modo_agitar,
  input  logic modo_girar,
  input  logic modo_centrifugar,
  output logic cheio,
  output logic vazio,
  output logic tempo1,
  output logic tempo2,
  output logic tempo3,
  output logic secar,
  output logic erro_modo
);

  localparam logic [CONT_W-1:0] CNT_MAX = '1;

  modo_e modo, modo_ant_q;
  logic [CONT_W-1:0] cnt_q, cnt_d;
  logic ja_girou_q, ja_girou_d;
  logic t1_d, t2_d, t3_d, sec_d;
  logic t1_q, t2_q, t3_q, sec_q;

  assign modo = decodifica(bomba_agua, modo_centrifugar,
                           modo_girar, modo_agitar);

  nivel_agua #(.NIVEL_MAX(NIVEL_MAX)) u_nivel (
    .clock   (clock),
    .reset_n (reset_n),
    .modo_i  (modo),
    .cheio_o (cheio),
    .vazio_o (vazio)
  );

  always_comb begin
    cnt_d = cnt_q;
    if (modo != modo_ant_q)  cnt_d = CONT_W'(1);
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;

    ja_girou_d = ja_girou_q;
    if (modo == MODO_GIRAR)       ja_girou_d = 1'b1;
    else if (modo == MODO_ENCHER) ja_girou_d = 1'b0;

    // Agitation phase is chosen by the flag as it stood before this edge.
    t1_d  = (modo == MODO_AGITAR) && !ja_girou_q
            && (cnt_d >= CONT_W'(T_AGITAR1));
    t3_d  = (modo == MODO_AGITAR) && ja_girou_q
            && (cnt_d >= CONT_W'(T_AGITAR2));
    t2_d  = (modo == MODO_GIRAR)
            && (cnt_d >= CONT_W'(T_GIRAR));
    sec_d = (modo == MODO_CENTRIF)
            && (cnt_d >= CONT_W'(T_CENTRIF));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      modo_ant_q <= MODO_PARADO;
      ja_girou_q <= 1'b0;
      t1_q       <= 1'b0;
      t2_q       <= 1'b0;
      t3_q       <= 1'b0;
      sec_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      modo_ant_q <= modo;
      ja_girou_q <= ja_girou_d;
      t1_q       <= t1_d;
      t2_q       <= t2_d;
      t3_q       <= t3_d;
      sec_q      <= sec_d;
    end
  end

  assign tempo1 = t1_q;
  assign tempo2 = t2_q;
  assign tempo3 = t3_q;
  assign secar  = sec_q;

`ifdef TEMPORIZADOR_ERRO_EN
  logic erro_q, multi;

  assign multi = (bomba_agua & modo_agitar)
               | (bomba_agua & modo_girar)
               | (bomba_agua & modo_centrifugar)
               | (modo_agitar & modo_girar)
               | (modo_agitar & modo_centrifugar)
               | (modo_girar & modo_centrifugar);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)   erro_q <= 1'b0;
    else if (multi) erro_q <= 1'b1;
  end

  assign erro_modo = erro_q;
`else
  assign erro_modo = 1'b0;
`endif

endmodule
